diferenciador: RTL

Inverse of the feedback accumulator. It accepts the accumulator's running value, a DATA_W-bit data word plus its overflow bit, one sample per valid/ready handshake. It recovers each STEP_W-bit increment as the modular difference between consecutive samples and queues the recovered steps in a small output FIFO with valid/ready. It sits on the consumer side of the accumulator output, so the original input stream can be rebuilt and checked.

---
 rtl/diferenciador_pkg.sv | 27 ++
 rtl/diferenciador_fifo_sync.sv | 81 ++++++++
 rtl/diferenciador.sv | 117 +++++++++++
 3 files changed

// File: rtl/diferenciador_pkg.sv
// -----------------------------------------------------------------------------
// diferenciador_pkg
// Shared constants for the step-recovery (differentiator) block:
//   - FSM state encodings (S_EMPTY, S_RUN, S_ERR)
//   - default widths DATA_W, STEP_W, DEPTH
//   - occupancy-width constant and helper to derive it from a FIFO depth
// -----------------------------------------------------------------------------
package diferenciador_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_EMPTY = 2'd0;  // waiting for a reference sample
  localparam state_t S_RUN   = 2'd1;  // reference held, recovering steps
  localparam state_t S_ERR   = 2'd2;  // out-of-range step seen, frozen until resync

  localparam int DATA_W = 6;
  localparam int STEP_W = 4;
  localparam int DEPTH  = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LEVEL_W = level_width(DEPTH);

endpackage

// File: rtl/diferenciador_fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of two so
// the read/write pointers wrap naturally.
// Ports:
//   clock, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_push, i_data : write request and data (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_data         : head entry, 0 when empty
//   o_full/o_empty : status flags
//   o_level        : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_sync #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  import diferenciador_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == {LW{1'b0}});
  assign o_level   = r_level;
  // A full FIFO never accepts a write, even if a read happens the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head presentation: zero when nothing is queued.
  always_comb begin
    o_data = {WIDTH{1'b0}};
    if (o_empty) begin
      o_data = {WIDTH{1'b0}};
    end else begin
      o_data = r_mem[r_rd_ptr];
    end
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/diferenciador.sv
// -----------------------------------------------------------------------------
// diferenciador
// Recovers the increments fed into a feedback accumulator from its running
// output. Each accepted sample {i_overflow, i_data} is subtracted (modulo
// 2^(DATA_W+1)) from the previous one; differences that fit in STEP_W bits are
// queued in an output FIFO, larger ones raise a sticky error.
// Ports:
//   clock, i_rst_n          : clock (rising edge), asynchronous active-low reset
//   i_valid, i_data,
//   i_overflow, o_ready     : sample input handshake
//   i_resync                : drop the reference sample and clear the error
//   o_valid, o_step, i_ready: recovered-step output handshake (FIFO head)
//   o_error                 : sticky out-of-range flag
//   o_level                 : output FIFO occupancy
// -----------------------------------------------------------------------------
module diferenciador #(
  parameter int DATA_W = diferenciador_pkg::DATA_W,
  parameter int STEP_W = diferenciador_pkg::STEP_W,
  parameter int DEPTH  = diferenciador_pkg::DEPTH
) (
  input  logic                    clock,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_overflow,
  output logic                    o_ready,
  input  logic                    i_resync,
  output logic                    o_valid,
  output logic [STEP_W-1:0]       o_step,
  input  logic                    i_ready,
  output logic                    o_error,
  output logic [$clog2(DEPTH):0]  o_level
);
  import diferenciador_pkg::*;

  localparam int SW = DATA_W + 1;

  state_t          r_state;
  logic [SW-1:0]   r_prev;
  logic            r_error;

  logic [SW-1:0]   w_sample;
  logic [SW-1:0]   w_diff;
  logic            w_in_range;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;

  assign w_sample = {i_overflow, i_data};
  // Unsigned wrap-around subtraction absorbs accumulator roll-over.
  assign w_diff   = w_sample - r_prev;
  // Step is legal when every bit above the step width is clear.
  assign w_in_range = (w_diff[SW-1:STEP_W] == {(SW-STEP_W){1'b0}});

  // Resync forces ready low so the sample presented that cycle stays pending.
  assign o_ready  = (r_state != S_ERR) && !w_full && !i_resync;
  assign w_accept = i_valid && o_ready;
  assign w_push   = w_accept && (r_state == S_RUN) && w_in_range;
  assign w_pop    = i_ready && !w_empty;

  assign o_valid  = !w_empty;
  assign o_error  = r_error;

  // Reference-tracking FSM with sticky range error.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
      r_prev  <= {SW{1'b0}};
      r_error <= 1'b0;
    end else if (i_resync) begin
      r_state <= S_EMPTY;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_prev  <= w_sample;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_prev <= w_sample;
            if (!w_in_range) begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  fifo_sync #(
    .WIDTH (STEP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_diff[STEP_W-1:0]),
    .i_pop   (w_pop),
    .o_data  (o_step),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

endmodule
